uart_fifo_dev: RTL

//  Memory-mapped 8N1 serial device with built-in baud generator and RX/TX FIFOs.

---
 rtl/uart_fifo_dev.sv | 361 ++++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_fifo_dev.sv
// uart_fifo_dev: memory-mapped 8N1 UART with baud generator, RX/TX FIFOs, sticky ovr/fe flags.
// Reads are combinational; data writes stall on wbusy_o while TX is full. Optional irq_o under UART_FIFO_DEV_IRQ_EN.

module uart_fifo_dev_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           push_dat_i,
  input  logic                   pop_i,
  output logic [W-1:0]           head_dat_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  // A pop frees the slot the simultaneous push lands in, so push+pop works when full.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end
endmodule

module uart_fifo_dev #(
  parameter int CLK_FREQ_HZ = 60000000,
  parameter int BAUD        = 115200,
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 16
) (
  input  logic        clk_i,
  input  logic        resetq_i,
  input  logic        rstrb_i,
  input  logic        wstrb_i,
  input  logic        sel_cntl_i,
  input  logic        sel_dat_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        wbusy_o,
  output logic        rbusy_o,
  output logic        irq_o,
  input  logic        rxd_i,
  output logic        txd_o
);
  localparam int DIV  = CLK_FREQ_HZ / BAUD;
  localparam int CNTW = $clog2(DIV);
  localparam int RXCW = $clog2(RX_DEPTH) + 1;
  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam logic [CNTW-1:0] BIT_END  = CNTW'(DIV - 1);
  localparam logic [CNTW-1:0] HALF_END = CNTW'(DIV / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  logic ctl_wr, dat_wr, dat_rd;
  logic clr_flags, rx_flush, tx_flush;
  logic rx_ie, tx_ie;

  assign ctl_wr    = sel_cntl_i & wstrb_i;
  assign dat_wr    = sel_dat_i & wstrb_i;
  assign dat_rd    = sel_dat_i & rstrb_i;
  assign clr_flags = ctl_wr & wdata_i[0];
  assign rx_flush  = ctl_wr & wdata_i[1];
  assign tx_flush  = ctl_wr & wdata_i[2];
  assign rbusy_o   = 1'b0;

  logic [7:0]      tx_head;
  logic [TXCW-1:0] tx_count_unused;
  logic            tx_full, tx_empty, tx_push, tx_pop, tx_busy;

  assign tx_push = dat_wr & ~tx_full;
  assign wbusy_o = dat_wr & tx_full;

  uart_fifo_dev_fifo #(.W(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (resetq_i),
    .flush_i    (tx_flush),
    .push_i     (tx_push),
    .push_dat_i (wdata_i[7:0]),
    .pop_i      (tx_pop),
    .head_dat_o (tx_head),
    .count_o    (tx_count_unused),
    .full_o     (tx_full),
    .empty_o    (tx_empty)
  );

  tx_state_e       tx_state_q, tx_state_d;
  logic [CNTW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_sh_q, tx_sh_d;
  logic            tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BIT_END);
  assign tx_busy    = ~tx_empty | (tx_state_q != TX_IDLE);

  always_ff @(posedge clk_i or negedge resetq_i) begin
    if (!resetq_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_bit_end ? '0 : tx_cnt_q + CNTW'(1);
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_pop) tx_state_d = TX_START;
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_sh_d  = {1'b0, tx_sh_q[7:1]};
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) tx_state_d = tx_pop ? TX_START : TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (tx_pop) tx_sh_d = tx_head;
  end

  // Back-to-back frames: the next byte is fetched on the last stop-bit cycle.
  always_comb begin
    tx_pop = 1'b0;
    txd_o  = 1'b1;
    case (tx_state_q)
      TX_IDLE:  tx_pop = ~tx_empty & ~tx_flush;
      TX_START: txd_o  = 1'b0;
      TX_DATA:  txd_o  = tx_sh_q[0];
      TX_STOP:  tx_pop = tx_bit_end & ~tx_empty & ~tx_flush;
      default:  txd_o  = 1'b1;
    endcase
  end

  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk_i or negedge resetq_i) begin
    if (!resetq_i) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rxd_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  rx_state_e       rx_state_q, rx_state_d;
  logic [CNTW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sh_q, rx_sh_d;
  logic            rx_stop_smp, rx_frame_ok, rx_frame_bad;

  always_ff @(posedge clk_i or negedge resetq_i) begin
    if (!resetq_i) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNTW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT;
        end
      end
      RX_WAIT: begin
        rx_cnt_d = '0;
        if (rx_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_stop_smp  = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_END);
    rx_frame_ok  = rx_stop_smp & rx_sync_q;
    rx_frame_bad = rx_stop_smp & ~rx_sync_q;
  end

  logic [7:0]      rx_head;
  logic [RXCW-1:0] rx_count;
  logic            rx_full, rx_empty, rx_nempty;

  assign rx_nempty = ~rx_empty;

  uart_fifo_dev_fifo #(.W(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i      (clk_i),
    .rst_n_i    (resetq_i),
    .flush_i    (rx_flush),
    .push_i     (rx_frame_ok),
    .push_dat_i (rx_sh_q),
    .pop_i      (dat_rd),
    .head_dat_o (rx_head),
    .count_o    (rx_count),
    .full_o     (rx_full),
    .empty_o    (rx_empty)
  );

  logic ovr_q, ovr_d, fe_q, fe_d, ovr_set;

  // A set event in the same cycle as a clear leaves the flag set.
  assign ovr_set = rx_frame_ok & rx_full & ~dat_rd & ~rx_flush;
  assign ovr_d   = (ovr_q & ~clr_flags) | ovr_set;
  assign fe_d    = (fe_q & ~clr_flags) | rx_frame_bad;

  always_ff @(posedge clk_i or negedge resetq_i) begin
    if (!resetq_i) begin
      ovr_q <= 1'b0;
      fe_q  <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      fe_q  <= fe_d;
    end
  end

`ifdef UART_FIFO_DEV_IRQ_EN
  logic rx_ie_q, tx_ie_q, irq_q, irq_d;
  logic unused_bits;

  assign irq_d       = (rx_ie_q & rx_nempty) | (tx_ie_q & ~tx_busy);
  assign unused_bits = &{1'b0, wdata_i[31:8], wdata_i[3]};

  always_ff @(posedge clk_i or negedge resetq_i) begin
    if (!resetq_i) begin
      rx_ie_q <= 1'b0;
      tx_ie_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (ctl_wr) begin
        rx_ie_q <= wdata_i[4];
        tx_ie_q <= wdata_i[5];
      end
      irq_q <= irq_d;
    end
  end

  assign rx_ie = rx_ie_q;
  assign tx_ie = tx_ie_q;
  assign irq_o = irq_q;
`else
  logic unused_bits;

  assign unused_bits = &{1'b0, wdata_i[31:8], wdata_i[5:3]};
  assign rx_ie       = 1'b0;
  assign tx_ie       = 1'b0;
  assign irq_o       = 1'b0;
`endif

  logic [31:0] status, rx_rd_dat;

  always_comb begin
    status              = '0;
    status[8]           = rx_nempty;
    status[9]           = tx_busy;
    status[10]          = tx_full;
    status[11]          = ovr_q;
    status[12]          = fe_q;
    status[13]          = rx_ie;
    status[14]          = tx_ie;
    status[16 +: RXCW]  = rx_count;
  end

  assign rx_rd_dat = rx_empty ? 32'd0 : {24'd0, rx_head};
  assign rdata_o   = (sel_cntl_i ? status : 32'd0) | (sel_dat_i ? rx_rd_dat : 32'd0);
endmodule
